// File: rtl/descramble.sv
// rtl/descramble.sv - 100BASE-TX receive descrambler, 2 bits/cycle; optional idle timeout under DESCRAMBLE_TIMEOUT_EN
module descramble #(
    parameter int LOCK_BITS = 29
`ifdef DESCRAMBLE_TIMEOUT_EN
    ,
    parameter int IDLE_BITS = 29,
    parameter int TIMEOUT   = 90250
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       signal_status,
    input  logic [1:0] nrz,
    input  logic [1:0] nrz_valid,
    output logic [1:0] data,
    output logic [1:0] data_valid,
    output logic       locked
);

`ifdef DESCRAMBLE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
`endif

    logic [10:0] key_q, key_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        locked_q, locked_d;
    logic [1:0]  data_q, data_d;
    logic [1:0]  dv_q, dv_d;

    logic [1:0]  nbits;
    logic [1:0]  nout;
    logic        lk;
    logic        s_bit;
    logic        p_bit;
    logic        d_bit;

`ifdef DESCRAMBLE_TIMEOUT_EN
    logic [7:0]    run_q, run_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          restart;
    logic          expire;
`endif

    // Walk the (up to two) received bits oldest first; the second bit sees the first bit's updates
    always_comb begin
        key_d  = key_q;
        cnt_d  = cnt_q;
        lk     = locked_q;
        data_d = 2'b00;
        nout   = 2'd0;
        s_bit  = 1'b0;
        p_bit  = 1'b0;
        d_bit  = 1'b0;
        // A count of 3 is not legal from the decoder; handle it as a full pair
        nbits  = (nrz_valid == 2'd3) ? 2'd2 : nrz_valid;
`ifdef DESCRAMBLE_TIMEOUT_EN
        run_d   = run_q;
        restart = 1'b0;
        expire  = 1'b0;
        timer_d = '0;
`endif
        for (int i = 0; i < 2; i++) begin
            if (2'(i) < nbits) begin
                s_bit = nrz[1-i];
                p_bit = key_d[10] ^ key_d[8];
                if (!lk) begin
                    // Idle is all ones, so the inverted line bit is the scrambler key bit itself
                    key_d = {key_d[9:0], ~s_bit};
                    if (p_bit == ~s_bit) begin
                        if (cnt_d != 8'hFF) begin
                            cnt_d = cnt_d + 8'd1;
                        end
                    end else begin
                        cnt_d = 8'd0;
                    end
                    if (cnt_d == 8'(LOCK_BITS)) begin
                        lk = 1'b1;
                    end
                end else begin
                    key_d = {key_d[9:0], p_bit};
                    d_bit = s_bit ^ p_bit;
                    // First emitted bit always lands in data[1]
                    if (nout == 2'd0) begin
                        data_d[1] = d_bit;
                    end else begin
                        data_d[0] = d_bit;
                    end
                    nout = nout + 2'd1;
`ifdef DESCRAMBLE_TIMEOUT_EN
                    if (d_bit) begin
                        if (run_d != 8'(IDLE_BITS)) begin
                            run_d = run_d + 8'd1;
                        end
                    end else begin
                        run_d = 8'd0;
                    end
                    if (run_d == 8'(IDLE_BITS)) begin
                        restart = 1'b1;
                    end
`endif
                end
            end
        end
        dv_d     = nout;
        locked_d = lk;
`ifdef DESCRAMBLE_TIMEOUT_EN
        // Timer only advances over cycles that began locked; an idle run restarts it
        if (locked_q && !restart) begin
            timer_d = timer_q + TW'(1);
            expire  = (timer_q == TW'(TIMEOUT - 1));
        end
        if (expire) begin
            locked_d = 1'b0;
            cnt_d    = 8'd0;
            run_d    = 8'd0;
            timer_d  = '0;
            data_d   = 2'b00;
            dv_d     = 2'd0;
        end
        if (!locked_d) begin
            run_d   = 8'd0;
            timer_d = '0;
        end
`endif
        // Loss of signal wins over everything; the key is kept so reacquisition is quick
        if (!signal_status) begin
            key_d    = key_q;
            cnt_d    = 8'd0;
            locked_d = 1'b0;
            data_d   = 2'b00;
            dv_d     = 2'd0;
`ifdef DESCRAMBLE_TIMEOUT_EN
            run_d    = 8'd0;
            timer_d  = '0;
`endif
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q    <= '0;
            cnt_q    <= '0;
            locked_q <= 1'b0;
            data_q   <= 2'b00;
            dv_q     <= 2'd0;
`ifdef DESCRAMBLE_TIMEOUT_EN
            run_q    <= '0;
            timer_q  <= '0;
`endif
        end else begin
            key_q    <= key_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
            data_q   <= data_d;
            dv_q     <= dv_d;
`ifdef DESCRAMBLE_TIMEOUT_EN
            run_q    <= run_d;
            timer_q  <= timer_d;
`endif
        end
    end

    assign data       = data_q;
    assign data_valid = dv_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_descramble.sv
// tb/tb_descramble.sv - directed self-checking bench for descramble
module tb_descramble;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       signal_status;
    logic [1:0] nrz;
    logic [1:0] nrz_valid;
    logic [1:0] data;
    logic [1:0] data_valid;
    logic       locked;

    int total = 0;
    int bad   = 0;

    logic [10:0] skey;
    int          bitn;
    int          flip_at;

    descramble #(
        .LOCK_BITS(29)
`ifdef DESCRAMBLE_TIMEOUT_EN
        ,
        .IDLE_BITS(29),
        .TIMEOUT(100)
`endif
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .signal_status(signal_status),
        .nrz          (nrz),
        .nrz_valid    (nrz_valid),
        .data         (data),
        .data_valid   (data_valid),
        .locked       (locked)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Reference scrambler x^11 + x^9 + 1, with an optional single line-bit error
    task automatic gen(input logic plain, output logic s);
        logic k;
        k    = skey[10] ^ skey[8];
        skey = {skey[9:0], k};
        bitn++;
        s    = plain ^ k ^ (bitn == flip_at);
    endtask

    task automatic cyc(input logic [1:0] nv, input logic [1:0] plain);
        logic s1, s0;
        s1 = 1'b0;
        s0 = 1'b0;
        if (nv != 2'd0) gen(plain[1], s1);
        if (nv >= 2'd2) gen(plain[0], s0);
        nrz       = {s1, s0};
        nrz_valid = nv;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        signal_status = 1'b1;
        nrz           = 2'b00;
        nrz_valid     = 2'd0;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        skey    = 11'h7FF;
        bitn    = 0;
        flip_at = -1;
    endtask

    initial begin
        rst_n         = 1'b0;
        signal_status = 1'b1;
        nrz           = 2'b11;
        nrz_valid     = 2'd2;
        skey          = 11'h7FF;
        bitn          = 0;
        flip_at       = -1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_locked", 32'(locked), 32'd0);
        chk("reset_dv", 32'(data_valid), 32'd0);
        chk("reset_data", 32'(data), 32'd0);
        do_reset();

        // Seed 7FF: bits 1-9 match a zero key by chance, bits 10-11 miss, cnt runs from bit 12 to 29 at bit 40
        repeat (19) cyc(2'd2, 2'b11);
        chk("acq_not_yet", 32'(locked), 32'd0);
        chk("acq_dv_before", 32'(data_valid), 32'd0);
        cyc(2'd2, 2'b11);
        chk("acq_locked", 32'(locked), 32'd1);
        chk("acq_lockcycle_dv", 32'(data_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(2'd2, 2'b11);
            chk("idle_data", 32'(data), 32'd3);
            chk("idle_dv", 32'(data_valid), 32'd2);
        end

        // /J/K/ = 11000 10001 emitted two bits per cycle, older bit in data[1]
        cyc(2'd2, 2'b11); chk("jk0", 32'(data), 32'h3);
        cyc(2'd2, 2'b00); chk("jk1", 32'(data), 32'h0);
        cyc(2'd2, 2'b01); chk("jk2", 32'(data), 32'h1);
        cyc(2'd2, 2'b00); chk("jk3", 32'(data), 32'h0);
        cyc(2'd2, 2'b01); chk("jk4", 32'(data), 32'h1);
        chk("jk_dv", 32'(data_valid), 32'd2);

        cyc(2'd0, 2'b11);
        chk("nv0_dv", 32'(data_valid), 32'd0);
        cyc(2'd3, 2'b11);
        chk("nv3_dv", 32'(data_valid), 32'd2);
        chk("nv3_data", 32'(data), 32'd3);

        // Signal loss: the pair presented that cycle is dropped, so the reference does not advance
        signal_status = 1'b0;
        nrz           = 2'b01;
        nrz_valid     = 2'd2;
        @(posedge clk);
        #1;
        signal_status = 1'b1;
        chk("los_locked", 32'(locked), 32'd0);
        chk("los_dv", 32'(data_valid), 32'd0);
        // Key is already in step, so lock lands on bit 29 = nrz[1] of the 15th pair
        repeat (14) cyc(2'd2, 2'b11);
        chk("reacq_not_yet", 32'(locked), 32'd0);
        cyc(2'd2, 2'b11);
        chk("reacq_locked", 32'(locked), 32'd1);
        chk("reacq_split_dv", 32'(data_valid), 32'd1);
        chk("reacq_split_data", 32'(data), 32'h2);
        cyc(2'd2, 2'b11);
        chk("reacq_full_dv", 32'(data_valid), 32'd2);

        // Asynchronous reset mid-stream takes effect without a clock edge
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_locked", 32'(locked), 32'd0);
        chk("async_rst_dv", 32'(data_valid), 32'd0);
        do_reset();

        // Alternating 1/2 valid: 13 pairs give 39 bits, the next single bit is bit 40
        for (int i = 0; i < 13; i++) begin
            cyc(2'd1, 2'b11);
            cyc(2'd2, 2'b11);
        end
        chk("alt_not_yet", 32'(locked), 32'd0);
        cyc(2'd1, 2'b11);
        chk("alt_locked", 32'(locked), 32'd1);
        chk("alt_lock_dv", 32'(data_valid), 32'd0);
        cyc(2'd2, 2'b11);
        chk("alt_dv2", 32'(data_valid), 32'd2);
        cyc(2'd1, 2'b11);
        chk("alt_dv1", 32'(data_valid), 32'd1);
        chk("alt_data1", 32'(data), 32'h2);
        do_reset();

        // Flip at bit 20 also poisons predictions at bits 29 and 31; cnt restarts at 32, lock at bit 60
        flip_at = 20;
        repeat (20) cyc(2'd2, 2'b11);
        chk("err_no_lock_40", 32'(locked), 32'd0);
        repeat (9) cyc(2'd2, 2'b11);
        chk("err_not_yet", 32'(locked), 32'd0);
        cyc(2'd2, 2'b11);
        chk("err_locked", 32'(locked), 32'd1);
        cyc(2'd2, 2'b11);
        chk("err_data", 32'(data), 32'd3);

`ifdef DESCRAMBLE_TIMEOUT_EN
        // Locked cycle #1 was the idle pair above; zeros fill #2..#100, and #100 drops lock
        repeat (98) cyc(2'd2, 2'b00);
        chk("to_still_locked", 32'(locked), 32'd1);
        cyc(2'd2, 2'b00);
        chk("to_dropped", 32'(locked), 32'd0);
        chk("to_dv", 32'(data_valid), 32'd0);
        repeat (15) cyc(2'd2, 2'b11);
        chk("to_relock", 32'(locked), 32'd1);
        for (int i = 0; i < 4; i++) begin
            repeat (40) cyc(2'd2, 2'b00);
            repeat (15) cyc(2'd2, 2'b11);
            chk("to_idle_keeps_lock", 32'(locked), 32'd1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
